mem_avalon_responder: RTL and testbench

- Word-addressed RAM acting as the memory-side responder on the CPU's Avalon-style bus.
- Serves instruction fetches and data load/store requests issued by the multicycle datapath (read, write, byteenable).
- Inserts a programmable number of wait states via waitrequest, so the CPU's stall handling can be exercised.
- Flags protocol and addressing errors on a sticky status output.

---
 rtl/mem_avalon_responder.sv | 113 +++++++++++
 tb/tb_mem_avalon_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_avalon_responder.sv
// Word-addressed RAM serving as the memory-side responder on an Avalon-style
// bus. Adds a fixed number of wait states per transfer and keeps a sticky
// bus_error flag for misaligned, out-of-range, conflicting or aborted requests.
module mem_avalon_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            state;
    logic [3:0]        count;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [31:0]       offset;
    logic [IDX_W-1:0]  word_idx;
    logic              addr_ok;
    logic              req;
    logic              xfer_bad;
    logic [31:0]       fetch_data;

    // Address decode relative to the base of the window; wrap-around is
    // intentional so addresses below BASE_ADDR land far out of range.
    assign offset     = address - BASE_ADDR;
    assign word_idx   = offset[IDX_W+1:2];
    assign addr_ok    = (offset[1:0] == 2'b00) &&
                        ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));
    assign req        = read | write;
    // Simultaneous read and write is ambiguous, so it is handled like a bad address.
    assign xfer_bad   = !addr_ok || (read && write);
    assign fetch_data = (read && !xfer_bad) ? mem[word_idx] : 32'h0;

    // The initiator is stalled whenever a request is pending outside ACK, and
    // always while reset is asserted.
    assign waitrequest = reset | (req & (state != S_ACK));

    // Transfer sequencing FSM; also registers readdata and the sticky error flag.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking assignments would create ordering races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= 4'd0;
            readdata  <= 32'h0;
            bus_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES > 0) begin
                            state <= S_WAIT;
                            count <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state    <= S_ACK;
                            readdata <= fetch_data;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        // Initiator dropped its request before acceptance.
                        state     <= S_IDLE;
                        bus_error <= 1'b1;
                    end else if (count == 4'd0) begin
                        state    <= S_ACK;
                        readdata <= fetch_data;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                    if (req && xfer_bad) begin
                        bus_error <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte-lane write port; the store commits on the edge that leaves ACK.
    // NOTE: the RAM array is deliberately not reset; clearing it would need a
    // per-word reset network and contents must survive a mid-transfer reset.
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACK && write && !xfer_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem[word_idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_avalon_responder.sv
// Self-checking bench for mem_avalon_responder: directed protocol scenarios on
// a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance, plus a randomized
// phase compared against a word-array reference model.
module tb_mem_avalon_responder;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] writedata = '0;
    logic        read2 = 1'b0, write2 = 1'b0;
    logic        read0 = 1'b0, write0 = 1'b0;
    logic        wq2, wq0;
    logic [31:0] rd2, rd0;
    logic        err2, err0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_avalon_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read2), .write(write2),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(wq2), .readdata(rd2), .bus_error(err2)
    );

    mem_avalon_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .read(read0), .write(write0),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(wq0), .readdata(rd0), .bus_error(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Lane merge as the spec describes it: byte i of the word takes the new
    // byte when byteenable[i] is set.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // One complete transfer. Called at posedge+1; returns at posedge+1 of the
    // cycle after ACK with the request already withdrawn.
    task automatic xfer(input bit sel0, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data,
                        output logic [31:0] rdata, output int hi, output logic err_at_ack);
        bit done;
        address    = addr;
        byteenable = be;
        writedata  = data;
        if (sel0) begin read0 = rd; write0 = wr; end
        else      begin read2 = rd; write2 = wr; end
        hi = 0;
        done = 0;
        rdata = 'x;
        err_at_ack = 1'bx;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if ((sel0 ? wq0 : wq2) === 1'b1) hi++;
            else begin
                rdata      = sel0 ? rd0 : rd2;
                err_at_ack = sel0 ? err0 : err2;
                done = 1;
            end
        end
        total++;
        assert (done) else begin
            bad++;
            $error("FAIL timeout: waitrequest never dropped for addr %08h", addr);
        end
        @(posedge clk);
        #1;
        read0 = 0; write0 = 0; read2 = 0; write2 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        read2 = 1'b1;
        read0 = 1'b1;
        address = BASE;
        @(negedge clk);
        check("rst_wq2", 32'(wq2), 32'd1);
        check("rst_wq0", 32'(wq0), 32'd1);
        check("rst_rd2", rd2, 32'h0);
        check("rst_err2", 32'(err2), 32'd0);
        check("rst_err0", 32'(err0), 32'd0);
        read2 = 1'b0;
        read0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r;
    int          hi;
    logic        ea;
    logic [31:0] model [16];
    logic        model_err;

    initial begin
        do_reset();

        // Basic write then read with 2 wait states.
        xfer(0, 0, 1, BASE + 32'h10, 4'hF, 32'hDEADBEEF, r, hi, ea);
        check("wr_wait", 32'(hi), 32'd3);
        xfer(0, 1, 0, BASE + 32'h10, 4'hF, 32'h0, r, hi, ea);
        check("rd_wait", 32'(hi), 32'd3);
        check("rd_data", r, 32'hDEADBEEF);

        // Byte lanes and a no-op byteenable.
        xfer(0, 0, 1, BASE + 32'h10, 4'b0010, 32'h00005500, r, hi, ea);
        xfer(0, 1, 0, BASE + 32'h10, 4'hF, 32'h0, r, hi, ea);
        check("lane_data", r, 32'hDEAD55EF);
        xfer(0, 0, 1, BASE + 32'h10, 4'b0000, 32'hFFFFFFFF, r, hi, ea);
        xfer(0, 1, 0, BASE + 32'h10, 4'hF, 32'h0, r, hi, ea);
        check("be0_data", r, 32'hDEAD55EF);

        // Reset in the middle of a write's wait phase.
        xfer(0, 0, 1, BASE + 32'h20, 4'hF, 32'hCAFEF00D, r, hi, ea);
        address = BASE + 32'h20;
        writedata = 32'h12345678;
        byteenable = 4'hF;
        write2 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_wq", 32'(wq2), 32'd1);
        write2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        xfer(0, 1, 0, BASE + 32'h20, 4'hF, 32'h0, r, hi, ea);
        check("midrst_data", r, 32'hCAFEF00D);
        check("midrst_err", 32'(err2), 32'd0);

        // Misaligned and out-of-range reads.
        xfer(0, 1, 0, BASE + 32'h2, 4'hF, 32'h0, r, hi, ea);
        check("mis_data", r, 32'h0);
        check("mis_err_ack", 32'(ea), 32'd0);
        check("mis_err_after", 32'(err2), 32'd1);
        check("mis_wait", 32'(hi), 32'd3);
        xfer(0, 1, 0, BASE + 32'(4 * DEPTH), 4'hF, 32'h0, r, hi, ea);
        check("oor_data", r, 32'h0);
        check("oor_err", 32'(err2), 32'd1);
        xfer(0, 1, 0, BASE + 32'h10, 4'hF, 32'h0, r, hi, ea);
        check("err_keep10", r, 32'hDEAD55EF);
        xfer(0, 1, 0, BASE + 32'h20, 4'hF, 32'h0, r, hi, ea);
        check("err_keep20", r, 32'hCAFEF00D);

        // Read and write together.
        do_reset();
        xfer(0, 1, 1, BASE + 32'h10, 4'hF, 32'h0, r, hi, ea);
        check("rw_data", r, 32'h0);
        check("rw_err", 32'(err2), 32'd1);
        xfer(0, 1, 0, BASE + 32'h10, 4'hF, 32'h0, r, hi, ea);
        check("rw_keep", r, 32'hDEAD55EF);

        // Initiator abort during WAIT.
        do_reset();
        address = BASE + 32'h10;
        writedata = 32'h0;
        byteenable = 4'hF;
        write2 = 1'b1;
        @(posedge clk);
        #1;
        write2 = 1'b0;
        @(negedge clk);
        check("abort_wq", 32'(wq2), 32'd0);
        @(posedge clk);
        #1;
        check("abort_err", 32'(err2), 32'd1);
        xfer(0, 1, 0, BASE + 32'h10, 4'hF, 32'h0, r, hi, ea);
        check("abort_wait", 32'(hi), 32'd3);
        check("abort_keep", r, 32'hDEAD55EF);

        // Randomized traffic against the word-array model.
        do_reset();
        model_err = 1'b0;
        for (int k = 0; k < 16; k++) begin
            model[k] = $urandom;
            xfer(0, 0, 1, BASE + 32'(4 * k), 4'hF, model[k], r, hi, ea);
        end
        for (int n = 0; n < 60; n++) begin
            int op, k;
            logic [31:0] d;
            logic [3:0]  be;
            op = int'($urandom_range(0, 9));
            k  = int'($urandom_range(0, 15));
            d  = $urandom;
            be = 4'($urandom);
            if (op < 4) begin
                xfer(0, 0, 1, BASE + 32'(4 * k), be, d, r, hi, ea);
                model[k] = merge(model[k], d, be);
            end else if (op < 8) begin
                xfer(0, 1, 0, BASE + 32'(4 * k), be, 32'h0, r, hi, ea);
                check("rnd_rd", r, model[k]);
            end else if (op == 8) begin
                xfer(0, 1, 0, BASE + 32'(4 * k) + 32'($urandom_range(1, 3)), be, 32'h0, r, hi, ea);
                model_err = 1'b1;
                check("rnd_mis", r, 32'h0);
            end else begin
                xfer(0, 0, 1, BASE + 32'(4 * (DEPTH + k)), be, d, r, hi, ea);
                model_err = 1'b1;
            end
            check("rnd_wait", 32'(hi), 32'd3);
            check("rnd_err", 32'(err2), 32'(model_err));
        end
        for (int k = 0; k < 16; k++) begin
            xfer(0, 1, 0, BASE + 32'(4 * k), 4'hF, 32'h0, r, hi, ea);
            check("rnd_final", r, model[k]);
        end

        // Zero-wait-state instance: back-to-back reads of words 0 and 1.
        xfer(1, 0, 1, BASE, 4'hF, 32'h0BAD0000, r, hi, ea);
        check("w0_wr_wait", 32'(hi), 32'd1);
        xfer(1, 0, 1, BASE + 32'h4, 4'hF, 32'h0BAD0001, r, hi, ea);
        xfer(1, 1, 0, BASE, 4'hF, 32'h0, r, hi, ea);
        check("w0_rd0_wait", 32'(hi), 32'd1);
        check("w0_rd0_data", r, 32'h0BAD0000);
        xfer(1, 1, 0, BASE + 32'h4, 4'hF, 32'h0, r, hi, ea);
        check("w0_rd1_wait", 32'(hi), 32'd1);
        check("w0_rd1_data", r, 32'h0BAD0001);
        check("w0_err", 32'(err0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
